kt8_reg_dump: RTL and testbench
===============================

Name: kt8_reg_dump

Overview:
- Read-side debug port for the KT8 data registers A, B and R.
- On a start request it snapshots all three 8-bit register outputs into one 24-bit frame.
- It shifts the frame out MSB-first on a synchronous serial link (sclk/data/frame) to an external logic analyser or debug host.
- Sits beside the register bank and only observes it; it never writes to any register.

Parameters:
- CLK_DIV, 4, system clocks per sclk half-period; legal range 1..255.

Ports:
- clk_i  input  1  system clock; all state changes on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- start_i  input  1  request a dump; sampled only in IDLE.
- hold_i  input  1  pause: freezes the divider and shifter while high.
- a_i  input  8  register A contents.
- b_i  input  8  register B contents.
- r_i  input  8  register R contents.
- sclk_o  output  1  serial clock; host samples data_o on the sclk_o rising edge.
- data_o  output  1  serial data; changes only on the sclk_o falling edge or at frame start.
- frame_o  output  1  high for the whole frame.
- busy_o  output  1  equals frame_o.
- done_o  output  1  one-cycle pulse at frame end.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low, on rst_ni.
- Reset values (all apply immediately on rst_ni low, including mid-frame; the partial frame is abandoned, with no done_o):
  - state = IDLE
  - sclk_o = 0, data_o = 0, frame_o = 0, done_o = 0
  - shift register = 0, bit count = 0, divider = 0
- States: IDLE, SHIFT.
- IDLE:
  - sclk_o = 0, data_o = 0, frame_o = 0.
  - start_i high at edge k:
    - shift register <= {a_i, b_i, r_i}, i.e. A[7] first, R[0] last.
    - bit count <= 23, divider <= 0, frame_o <= 1, data_o <= a_i[7], state <= SHIFT.
  - hold_i is ignored in IDLE.
- SHIFT:
  - Each cycle with hold_i = 0, the divider increments.
  - When the divider = CLK_DIV-1: toggle sclk_o and clear the divider.
  - hold_i = 1 freezes the divider, sclk_o, data_o and the counters; the frame resumes exactly where it stopped.
  - On each falling toggle (sclk_o 1->0):
    - If bit count = 0: state <= IDLE, frame_o <= 0, data_o <= 0, done_o <= 1.
    - Else: shift left by one, data_o <= next bit, bit count decrements.
  - start_i is ignored while in SHIFT; there is no queueing.
- Timing (no hold):
  - First sclk_o rise at edge k+CLK_DIV.
  - Bit n (n = 0..23) is valid at sclk rise number n+1.
  - Frame end, where done_o rises and frame_o falls, at edge k+48*CLK_DIV.
- Snapshot: register values are captured only at the start edge. Later changes to a_i, b_i or r_i do not affect the frame in flight.
- done_o: high for exactly one cycle, then 0. A start_i during that cycle is accepted, since the state is already IDLE, giving back-to-back frames.
- Divider width: 8 bits.
- CLK_DIV = 1 gives sclk at clk/2.

Test Plan:
- Reset:
  - Stimulus: hold rst_ni low with start_i high.
  - Required: all outputs 0, no frame begins. After release with start_i low, outputs stay idle for 50 cycles.
- Basic frame:
  - Stimulus: CLK_DIV = 4, A = 0xA5, B = 0x3C, R = 0xFF, one-cycle start.
  - Required: frame_o high the next cycle. Bits sampled at 24 sclk rises = 0xA53CFF. done_o is a single pulse exactly 192 cycles after start. frame_o falls on the same edge.
- Snapshot and busy ignore:
  - Stimulus: start with A = 0x12, B = 0x34, R = 0x56. Change all inputs to 0x00 at cycle 10. Pulse start_i at cycle 50.
  - Required: received 0x123456, a single done_o, no second frame.
- Back-to-back:
  - Stimulus: assert start_i in the done_o cycle with A = 0x01, B = 0x02, R = 0x03.
  - Required: a second frame starts immediately and receives 0x010203.
- Hold:
  - Stimulus: hold_i high for 37 cycles mid-frame.
  - Required: sclk_o and data_o are frozen. Received data is unchanged. done_o arrives at 192+37 cycles.
- Reset mid-frame and CLK_DIV = 1:
  - Stimulus: drop rst_ni at cycle 20 of a frame.
  - Required: outputs go to 0 asynchronously, no done_o. A new frame afterwards is correct.
  - Stimulus: with CLK_DIV = 1, dump A = 0x80, B = 0x00, R = 0x01.
  - Required: frame ends at 48 cycles, received 0x800001.

Source files
------------

// File: rtl/kt8_reg_dump.sv
// kt8_reg_dump: read-only debug port for the KT8 data registers.
// On start it snapshots {A, B, R} into a 24-bit frame and shifts it out
// MSB-first on a synchronous serial link (sclk/data/frame). It never
// writes back to the register bank.
module kt8_reg_dump #(
    parameter int unsigned CLK_DIV = 4  // system clocks per sclk half-period, 1..255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       hold_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [7:0] r_i,
    output logic       sclk_o,
    output logic       data_o,
    output logic       frame_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    // Divider terminal count; the divider is 8 bits wide.
    localparam logic [7:0] DivMax = 8'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [23:0] shreg_q, shreg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sclk_q, sclk_d;
    logic        data_q, data_d;
    logic        frame_q, frame_d;
    logic        done_q, done_d;

    logic        div_wrap;

    assign div_wrap = (div_q == DivMax);

    // Next-state logic: frame launch in idle, divided sclk and shifting in shift.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        sclk_d  = sclk_q;
        data_d  = data_q;
        frame_d = frame_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                sclk_d  = 1'b0;
                data_d  = 1'b0;
                frame_d = 1'b0;
                // hold_i has no effect here; only start_i matters.
                if (start_i) begin
                    shreg_d = {a_i, b_i, r_i};
                    cnt_d   = 5'd23;
                    div_d   = 8'd0;
                    frame_d = 1'b1;
                    data_d  = a_i[7];
                    state_d = StShift;
                end
            end

            StShift: begin
                // start_i is ignored while a frame is in flight.
                if (!hold_i) begin
                    if (div_wrap) begin
                        div_d  = 8'd0;
                        sclk_d = ~sclk_q;
                        // Falling toggle: the host has sampled the current bit.
                        if (sclk_q) begin
                            if (cnt_q == 5'd0) begin
                                state_d = StIdle;
                                frame_d = 1'b0;
                                data_d  = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                shreg_d = {shreg_q[22:0], 1'b0};
                                data_d  = shreg_q[22];
                                cnt_d   = cnt_q - 5'd1;
                            end
                        end
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register; reset abandons any partial frame without a done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            div_q   <= 8'd0;
            shreg_q <= 24'd0;
            cnt_q   <= 5'd0;
            sclk_q  <= 1'b0;
            data_q  <= 1'b0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            sclk_q  <= sclk_d;
            data_q  <= data_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        sclk_o  = sclk_q;
        data_o  = data_q;
        frame_o = frame_q;
        busy_o  = frame_q;
        done_o  = done_q;
    end

endmodule

// File: tb/tb_kt8_reg_dump.sv
// Directed bench for kt8_reg_dump: one instance at CLK_DIV=4, one at CLK_DIV=1.
module tb_kt8_reg_dump;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start4 = 1'b0;
    logic       start1 = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] a = 8'd0, b = 8'd0, r = 8'd0;

    logic sclk4, data4, frame4, busy4, done4;
    logic sclk1, data1, frame1, busy1, done1;

    int tests = 0;
    int fails = 0;

    // Selects which instance the frame tasks drive and observe.
    logic use1 = 1'b0;
    logic m_done, m_frame;
    assign m_done  = use1 ? done1 : done4;
    assign m_frame = use1 ? frame1 : frame4;

    always #5 clk = ~clk;

    kt8_reg_dump #(.CLK_DIV(4)) dut4 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .start_i(start4),
        .hold_i (hold),
        .a_i    (a),
        .b_i    (b),
        .r_i    (r),
        .sclk_o (sclk4),
        .data_o (data4),
        .frame_o(frame4),
        .busy_o (busy4),
        .done_o (done4)
    );

    kt8_reg_dump #(.CLK_DIV(1)) dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .start_i(start1),
        .hold_i (hold),
        .a_i    (a),
        .b_i    (b),
        .r_i    (r),
        .sclk_o (sclk1),
        .data_o (data1),
        .frame_o(frame1),
        .busy_o (busy1),
        .done_o (done1)
    );

    // Host-side receivers: sample data on every sclk rise.
    logic [63:0] rx4_sh = '0, rx1_sh = '0;
    int          rx4_n = 0, rx1_n = 0;

    always @(posedge sclk4) begin
        rx4_sh = {rx4_sh[62:0], data4};
        rx4_n++;
    end

    always @(posedge sclk1) begin
        rx1_sh = {rx1_sh[62:0], data1};
        rx1_n++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the start edge.
    task automatic pulse_start();
        if (use1) start1 = 1'b1;
        else start4 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    // Counts cycles from the start edge until done is seen (bounded), with
    // optional input change, stray start and hold window along the way.
    task automatic wait_done(input int limit, input int chg_at, input int stray_at,
                             input int hold_at, input int hold_len,
                             output int cyc, output bit frozen_ok);
        logic [1:0] snap;
        snap = 2'b00;
        cyc = 0;
        frozen_ok = 1'b1;
        while (cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (cyc == chg_at) begin
                a = 8'h00; b = 8'h00; r = 8'h00;
            end
            if (cyc == stray_at) start4 = 1'b1;
            if (cyc == stray_at + 1) start4 = 1'b0;
            if (hold_len > 0) begin
                if (cyc > hold_at && cyc <= hold_at + hold_len) begin
                    if ({sclk4, data4} !== snap) frozen_ok = 1'b0;
                end
                if (cyc == hold_at) begin
                    hold = 1'b1;
                    snap = {sclk4, data4};
                end
                if (cyc == hold_at + hold_len) hold = 1'b0;
            end
            if (m_done) break;
        end
    endtask

    int cyc, base, nd, nf, act;
    bit frz;

    initial begin
        // Reset held low with start requested on both instances.
        start4 = 1'b1;
        start1 = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst_outs4", {27'd0, sclk4, data4, frame4, busy4, done4}, 32'd0);
        check_eq("rst_outs1", {27'd0, sclk1, data1, frame1, busy1, done1}, 32'd0);
        start4 = 1'b0;
        start1 = 1'b0;
        rst_n = 1'b1;
        act = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sclk4 | data4 | frame4 | busy4 | done4 | sclk1 | data1 | frame1 | busy1 | done1)
                act++;
        end
        check_eq("idle_50", act, 0);

        // Basic frame at CLK_DIV=4.
        use1 = 1'b0;
        a = 8'hA5; b = 8'h3C; r = 8'hFF;
        base = rx4_n;
        pulse_start();
        check_eq("basic_frame_next", {31'd0, frame4}, 32'd1);
        check_eq("basic_busy", {31'd0, busy4}, 32'd1);
        check_eq("basic_first_bit", {31'd0, data4}, 32'd1);
        wait_done(1000, -1, -1, 0, 0, cyc, frz);
        check_eq("basic_done_cyc", cyc, 192);
        check_eq("basic_frame_fall", {31'd0, frame4}, 32'd0);
        check_eq("basic_bits", rx4_n - base, 24);
        check_eq("basic_data", {8'd0, rx4_sh[23:0]}, 32'hA53CFF);

        // Back-to-back: start while done is high.
        check_eq("b2b_in_done", {31'd0, done4}, 32'd1);
        a = 8'h01; b = 8'h02; r = 8'h03;
        base = rx4_n;
        pulse_start();
        check_eq("basic_done_single", {31'd0, done4}, 32'd0);
        check_eq("b2b_frame", {31'd0, frame4}, 32'd1);
        wait_done(1000, -1, -1, 0, 0, cyc, frz);
        check_eq("b2b_done_cyc", cyc, 192);
        check_eq("b2b_data", {8'd0, rx4_sh[23:0]}, 32'h010203);
        check_eq("b2b_bits", rx4_n - base, 24);

        // Snapshot and busy ignore.
        @(negedge clk);
        a = 8'h12; b = 8'h34; r = 8'h56;
        base = rx4_n;
        pulse_start();
        wait_done(1000, 10, 50, 0, 0, cyc, frz);
        check_eq("snap_done_cyc", cyc, 192);
        check_eq("snap_data", {8'd0, rx4_sh[23:0]}, 32'h123456);
        nd = 0;
        nf = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done4) nd++;
            if (frame4) nf++;
        end
        check_eq("snap_no_second_done", nd, 0);
        check_eq("snap_no_second_frame", nf, 0);

        // Hold for 37 cycles mid-frame.
        a = 8'h5A; b = 8'h96; r = 8'h0F;
        base = rx4_n;
        pulse_start();
        wait_done(1000, -1, -1, 100, 37, cyc, frz);
        check_eq("hold_done_cyc", cyc, 229);
        check_eq("hold_frozen", {31'd0, frz}, 32'd1);
        check_eq("hold_data", {8'd0, rx4_sh[23:0]}, 32'h5A960F);
        check_eq("hold_bits", rx4_n - base, 24);

        // Asynchronous reset mid-frame.
        @(negedge clk);
        a = 8'h77; b = 8'h88; r = 8'h99;
        pulse_start();
        repeat (20) @(negedge clk);
        check_eq("midrst_pre_frame", {31'd0, frame4}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_eq("midrst_async", {27'd0, sclk4, data4, frame4, busy4, done4}, 32'd0);
        nd = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done4) nd++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done4 | frame4) nd++;
        end
        check_eq("midrst_no_done", nd, 0);
        a = 8'hDE; b = 8'hAD; r = 8'hBE;
        base = rx4_n;
        pulse_start();
        wait_done(1000, -1, -1, 0, 0, cyc, frz);
        check_eq("post_rst_done_cyc", cyc, 192);
        check_eq("post_rst_data", {8'd0, rx4_sh[23:0]}, 32'hDEADBE);

        // CLK_DIV = 1 instance.
        @(negedge clk);
        use1 = 1'b1;
        a = 8'h80; b = 8'h00; r = 8'h01;
        base = rx1_n;
        pulse_start();
        check_eq("div1_frame", {31'd0, frame1}, 32'd1);
        wait_done(200, -1, -1, 0, 0, cyc, frz);
        check_eq("div1_done_cyc", cyc, 48);
        check_eq("div1_bits", rx1_n - base, 24);
        check_eq("div1_data", {8'd0, rx1_sh[23:0]}, 32'h800001);
        @(negedge clk);
        check_eq("div1_done_single", {31'd0, done1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
